init_port: RTL and testbench

INIT_PORT -- requirements
Module: init_port

---
 rtl/init_port.sv | 145 ++++++++++++++
 tb/tb_init_port.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/init_port.sv
// Initiator bus port: serialises a captured address (and optional write byte)
// LSB first under arbiter grant, and deserialises incoming read bits into bytes.
module init_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic        arbiter_grant,
  input  logic [15:0] init_addr_out,
  input  logic        init_addr_out_valid,
  input  logic [7:0]  init_data_out,
  input  logic        init_data_out_valid,
  input  logic        init_rw,
  input  logic        init_ready,
  input  logic        target_split,
  input  logic        target_ack,
  input  logic        bus_data_in,
  input  logic        bus_data_in_valid,
  output logic        bus_data_out,
  output logic        bus_data_out_valid,
  output logic        bus_mode,
  output logic [7:0]  init_data_in,
  output logic        init_data_in_valid,
  output logic        init_grant,
  output logic        arbiter_req,
  output logic        init_ack,
  output logic        init_split_ack,
  output logic        bus_init_ready,
  output logic        bus_init_rw
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic [15:0] addr_reg, addr_nxt;
  logic [7:0]  data_reg, data_nxt;
  logic        pending, pending_nxt;
  logic [4:0]  bit_cnt, cnt_nxt;
  logic        tx_bit_nxt, tx_valid_nxt, tx_mode_nxt;
  logic [2:0]  rx_count;
  logic [7:0]  rx_shift;

  assign init_grant     = arbiter_grant;
  assign arbiter_req    = init_req;
  assign bus_init_ready = init_ready;
  assign bus_init_rw    = init_rw;
  assign init_ack       = target_ack;
  assign init_split_ack = target_split;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      addr_reg           <= '0;
      data_reg           <= '0;
      pending            <= 1'b0;
      bit_cnt            <= '0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      bus_mode           <= 1'b0;
    end else begin
      state              <= state_nxt;
      addr_reg           <= addr_nxt;
      data_reg           <= data_nxt;
      pending            <= pending_nxt;
      bit_cnt            <= cnt_nxt;
      bus_data_out       <= tx_bit_nxt;
      bus_data_out_valid <= tx_valid_nxt;
      bus_mode           <= tx_mode_nxt;
    end
  end

  // A cycle without grant emits nothing and holds the bit position and mode.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_reg;
    data_nxt     = data_reg;
    pending_nxt  = pending;
    cnt_nxt      = bit_cnt;
    tx_bit_nxt   = bus_data_out;
    tx_valid_nxt = 1'b0;
    tx_mode_nxt  = bus_mode;
    unique case (state)
      IDLE: begin
        tx_bit_nxt  = 1'b0;
        tx_mode_nxt = 1'b0;
        if (init_addr_out_valid) begin
          addr_nxt  = init_addr_out;
          cnt_nxt   = '0;
          state_nxt = ADDR;
          if (init_data_out_valid) begin
            data_nxt    = init_data_out;
            pending_nxt = 1'b1;
          end else begin
            pending_nxt = 1'b0;
          end
        end
      end
      ADDR: begin
        if (arbiter_grant) begin
          tx_bit_nxt   = addr_reg[bit_cnt[3:0]];
          tx_valid_nxt = 1'b1;
          tx_mode_nxt  = 1'b0;
          if (bit_cnt == 5'd15) begin
            cnt_nxt   = '0;
            state_nxt = pending ? DATA : IDLE;
          end else begin
            cnt_nxt = bit_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (arbiter_grant) begin
          tx_bit_nxt   = data_reg[bit_cnt[2:0]];
          tx_valid_nxt = 1'b1;
          tx_mode_nxt  = 1'b1;
          if (bit_cnt == 5'd7) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = bit_cnt + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final bit is merged directly into the presented byte so it appears the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count           <= '0;
      rx_shift           <= '0;
      init_data_in       <= '0;
      init_data_in_valid <= 1'b0;
    end else begin
      init_data_in_valid <= bus_data_in_valid && (rx_count == 3'd7);
      if (bus_data_in_valid) begin
        rx_shift[rx_count] <= bus_data_in;
        rx_count           <= rx_count + 3'd1;
        if (rx_count == 3'd7)
          init_data_in <= {bus_data_in, rx_shift[6:0]};
      end
    end
  end

endmodule

// File: tb/tb_init_port.sv
// Randomised self-checking bench for init_port: transmitted streams and received
// bytes are compared against a bit-list model built from address/data values.
module tb_init_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_req, arbiter_grant, init_addr_out_valid, init_data_out_valid;
  logic [15:0] init_addr_out;
  logic [7:0]  init_data_out;
  logic        init_rw, init_ready, target_split, target_ack;
  logic        bus_data_in, bus_data_in_valid;
  logic        bus_data_out, bus_data_out_valid, bus_mode;
  logic [7:0]  init_data_in;
  logic        init_data_in_valid, init_grant, arbiter_req, init_ack;
  logic        init_split_ack, bus_init_ready, bus_init_rw;

  int checks = 0;
  int errors = 0;

  bit          tx_bits[$];
  bit          tx_modes[$];
  int          gap_err = 0;
  int          rx_pulses = 0;
  logic [7:0]  rx_last = '0;
  logic        grant_at_edge = 1'b0;

  always #5 clk = ~clk;

  init_port dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .arbiter_grant(arbiter_grant),
    .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
    .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
    .init_rw(init_rw), .init_ready(init_ready), .target_split(target_split),
    .target_ack(target_ack), .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid), .bus_mode(bus_mode),
    .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
    .init_grant(init_grant), .arbiter_req(arbiter_req), .init_ack(init_ack),
    .init_split_ack(init_split_ack), .bus_init_ready(bus_init_ready), .bus_init_rw(bus_init_rw)
  );

  // A valid output bit is only legal if grant was high at the edge that produced it.
  always @(posedge clk) grant_at_edge <= arbiter_grant;

  always @(negedge clk) begin
    if (bus_data_out_valid) begin
      tx_bits.push_back(bus_data_out);
      tx_modes.push_back(bus_mode);
      if (!grant_at_edge) gap_err++;
    end
    if (init_data_in_valid) begin
      rx_pulses++;
      rx_last = init_data_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] v);
    {arbiter_grant, init_req, init_ready, init_rw, target_ack, target_split} = v;
    #1;
    checkOutput("passthru",
                {init_grant, arbiter_req, bus_init_ready, bus_init_rw, init_ack, init_split_ack}, v);
    step();
  endtask

  // grant_mode: 0 = always granted, 1 = random grant, 2 = three-cycle stall mid-address
  task automatic run_tx(input logic [15:0] addr, input logic [7:0] data, input bit with_data,
                        input int grant_mode);
    int          n;
    logic [23:0] got_bits, got_modes, exp_bits, exp_modes;
    n = with_data ? 24 : 16;
    tx_bits.delete();
    tx_modes.delete();
    gap_err = 0;
    init_addr_out       = addr;
    init_data_out       = data;
    init_addr_out_valid = 1'b1;
    init_data_out_valid = with_data;
    step();
    init_addr_out_valid = 1'b0;
    init_data_out_valid = 1'b0;
    for (int c = 0; c < 400 && tx_bits.size() < n; c++) begin
      case (grant_mode)
        0:       arbiter_grant = 1'b1;
        1:       arbiter_grant = ($urandom_range(0, 3) != 0);
        default: arbiter_grant = !(c >= 6 && c < 9);
      endcase
      if (c == 3) begin
        init_addr_out       = ~addr;
        init_data_out       = ~data;
        init_addr_out_valid = 1'b1;
        init_data_out_valid = 1'b1;
      end else begin
        init_addr_out_valid = 1'b0;
        init_data_out_valid = 1'b0;
      end
      step();
    end
    arbiter_grant       = 1'b0;
    init_addr_out_valid = 1'b0;
    init_data_out_valid = 1'b0;
    step();
    step();
    checkOutput("tx_count", tx_bits.size(), n);
    checkOutput("tx_gap", gap_err, 0);
    checkOutput("tx_idle_mode", bus_mode, 1'b0);
    checkOutput("tx_idle_valid", bus_data_out_valid, 1'b0);
    got_bits  = '0;
    got_modes = '0;
    for (int i = 0; i < tx_bits.size() && i < 24; i++) begin
      got_bits[i]  = tx_bits[i];
      got_modes[i] = tx_modes[i];
    end
    exp_bits  = with_data ? {data, addr} : {8'h00, addr};
    exp_modes = with_data ? 24'hFF0000 : 24'h000000;
    checkOutput("tx_bits", got_bits, exp_bits);
    checkOutput("tx_modes", got_modes, exp_modes);
  endtask

  task automatic send_rx_bits(input logic [7:0] b, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus_data_in_valid = 1'b0;
        bus_data_in       = 1'($urandom);
        step();
      end
      bus_data_in       = b[i];
      bus_data_in_valid = 1'b1;
      step();
    end
    bus_data_in_valid = 1'b0;
  endtask

  task automatic check_rx(input logic [7:0] b);
    step();
    step();
    checkOutput("rx_pulses", rx_pulses, 1);
    checkOutput("rx_byte", rx_last, b);
    checkOutput("rx_hold", init_data_in, b);
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0;
    {init_req, arbiter_grant, init_addr_out_valid, init_data_out_valid} = '0;
    init_addr_out = '0;
    init_data_out = '0;
    {init_rw, init_ready, target_split, target_ack} = '0;
    bus_data_in = 1'b0;
    bus_data_in_valid = 1'b0;
    step();
    step();
    checkOutput("rst_out_valid", bus_data_out_valid, 1'b0);
    checkOutput("rst_out_bit", bus_data_out, 1'b0);
    checkOutput("rst_mode", bus_mode, 1'b0);
    checkOutput("rst_rx_byte", init_data_in, 8'h00);
    checkOutput("rst_rx_valid", init_data_in_valid, 1'b0);
    rst_n = 1'b1;
    step();

    applyStimulus(6'b111111);
    applyStimulus(6'b000000);
    applyStimulus(6'b000011);
    applyStimulus(6'b101010);
    applyStimulus(6'b010101);
    for (int i = 0; i < 5; i++) applyStimulus(6'($urandom));
    {arbiter_grant, init_req, init_ready, init_rw, target_ack, target_split} = '0;
    step();

    run_tx(16'hA55A, 8'h3C, 1'b1, 0);
    run_tx(16'hA55A, 8'h3C, 1'b1, 2);
    run_tx(16'h1234, 8'hFF, 1'b0, 0);
    for (int t = 0; t < 6; t++)
      run_tx(16'($urandom), 8'($urandom), 1'($urandom), 1);

    rx_pulses = 0;
    send_rx_bits(8'h96, 8, 1'b0);
    check_rx(8'h96);
    for (int t = 0; t < 4; t++) begin
      rb = 8'($urandom);
      rx_pulses = 0;
      send_rx_bits(rb, 8, 1'b1);
      check_rx(rb);
    end

    rb = 8'($urandom);
    rx_pulses = 0;
    fork
      run_tx(16'($urandom), 8'($urandom), 1'b1, 1);
      send_rx_bits(rb, 8, 1'b1);
    join
    checkOutput("conc_rx_pulses", rx_pulses, 1);
    checkOutput("conc_rx_byte", init_data_in, rb);

    rx_pulses = 0;
    send_rx_bits(8'hFF, 4, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rx_byte", init_data_in, 8'h00);
    checkOutput("mid_rst_rx_valid", init_data_in_valid, 1'b0);
    checkOutput("mid_rst_mode", bus_mode, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("mid_rst_no_pulse", rx_pulses, 0);
    send_rx_bits(8'h5A, 8, 1'b0);
    check_rx(8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
